// File: rtl/kgp_risc_pkg.sv
// Shared constants and fetch-state encodings for the KGP-RISC core.
// The HALT opcode only matters when IFU_HALT_EN is defined.
package kgp_risc_pkg;

   localparam int unsigned IFU_ADDR_W = 5;
   localparam int unsigned IFU_DATA_W = 32;

   localparam logic [5:0] OPC_HALT = 6'b111111;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry holding register (instruction + PC) behind the fetch output register.
// Flush wins over load; load wins over drain so a drain and refill can share a cycle.
module ifu_skid_buf
   import kgp_risc_pkg::*;
#(
   parameter int unsigned ADDR_W = IFU_ADDR_W,
   parameter int unsigned DATA_W = IFU_DATA_W
) (
   input  logic              clka,
   input  logic              rsta_n,
   input  logic              load_i,
   input  logic              drain_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [ADDR_W-1:0] pc_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      pc_d    = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         pc_d    = pc_i;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// KGP-RISC fetch stage: drives the instruction BRAM, absorbs its 1-cycle read latency and
// presents instructions over valid/ready. Optional HALT stop is enabled by IFU_HALT_EN.
module instr_fetch_unit
   import kgp_risc_pkg::*;
#(
   parameter int unsigned ADDR_W   = IFU_ADDR_W,
   parameter int unsigned DATA_W   = IFU_DATA_W,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clka,
   input  logic              rsta_n,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              halted
);

   localparam logic [ADDR_W-1:0] RstPc = ADDR_W'(RESET_PC);

   fetch_state_e      st_q, st_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              ifl_q, ifl_d;
   logic [ADDR_W-1:0] ifl_pc_q, ifl_pc_d;
   logic              ov_q, ov_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;

   logic              skid_valid, skid_load, skid_drain, skid_flush;
   logic [DATA_W-1:0] skid_data;
   logic [ADDR_W-1:0] skid_pc;
   logic              out_free, issue;
   logic [1:0]        occ;
`ifdef IFU_HALT_EN
   logic              halt_cap;
`endif

   // Outstanding work downstream of the BRAM; at most two slots can absorb returns.
   always_comb begin
      occ   = {1'b0, ov_q & ~instr_ready} + {1'b0, skid_valid} + {1'b0, ifl_q};
      issue = (st_q == ST_RUN) && !redirect_valid && (occ < 2'd2);
   end

   always_comb begin
      st_d       = st_q;
      pc_d       = pc_q;
      ifl_d      = 1'b0;
      ifl_pc_d   = ifl_pc_q;
      ov_d       = ov_q;
      instr_d    = instr_q;
      ipc_d      = ipc_q;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_flush = 1'b0;
      out_free   = ~ov_q | instr_ready;
`ifdef IFU_HALT_EN
      halt_cap   = 1'b0;
`endif
      if (redirect_valid) begin
         // Clearing ifl_q squashes any return arriving this cycle.
         st_d       = ST_RUN;
         pc_d       = redirect_pc;
         ov_d       = 1'b0;
         skid_flush = 1'b1;
      end else begin
         if (st_q == ST_WAIT) begin
            st_d = ST_RUN;
         end
         if (out_free) begin
            if (skid_valid) begin
               ov_d       = 1'b1;
               instr_d    = skid_data;
               ipc_d      = skid_pc;
               skid_drain = 1'b1;
               skid_load  = ifl_q;
            end else if (ifl_q) begin
               ov_d    = 1'b1;
               instr_d = mem_dout;
               ipc_d   = ifl_pc_q;
            end else begin
               ov_d = 1'b0;
            end
         end else if (ifl_q) begin
            skid_load = 1'b1;
         end
         if (issue) begin
            pc_d     = pc_q + 1'b1;
            ifl_d    = 1'b1;
            ifl_pc_d = pc_q;
         end
`ifdef IFU_HALT_EN
         // HALT itself is delivered; everything younger is dropped.
         halt_cap = out_free && (skid_valid || ifl_q) && (instr_d[31:26] == OPC_HALT);
         if (halt_cap) begin
            st_d       = ST_HALT;
            ifl_d      = 1'b0;
            skid_flush = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         st_q     <= ST_WAIT;
         pc_q     <= RstPc;
         ifl_q    <= 1'b0;
         ifl_pc_q <= '0;
         ov_q     <= 1'b0;
         instr_q  <= '0;
         ipc_q    <= '0;
      end else begin
         st_q     <= st_d;
         pc_q     <= pc_d;
         ifl_q    <= ifl_d;
         ifl_pc_q <= ifl_pc_d;
         ov_q     <= ov_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
      end
   end

   ifu_skid_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clka    (clka),
      .rsta_n  (rsta_n),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .flush_i (skid_flush),
      .data_i  (mem_dout),
      .pc_i    (ifl_pc_q),
      .valid_o (skid_valid),
      .data_o  (skid_data),
      .pc_o    (skid_pc)
   );

   assign mem_en      = issue;
   assign mem_addr    = pc_q;
   assign instr_valid = ov_q;
   assign instr       = instr_q;
   assign instr_pc    = ipc_q;
`ifdef IFU_HALT_EN
   assign halted      = (st_q == ST_HALT);
`else
   assign halted      = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage of the KGP-RISC core. It sits directly downstream of the 32x32 instruction block RAM (blk_mem_gen_v7_3). It drives the RAM address and enable, absorbs the RAM's 1-cycle synchronous read latency, and hands instructions with their PC to decode over a valid/ready handshake. It also supports branch/jump redirect from execute.

Parameters:
ADDR_W, 5, instruction memory address width in words (depth 2^ADDR_W).
DATA_W, 32, instruction width.
RESET_PC, 0, first fetch address after reset.

Ports:
clka  in  1  clock, shared with instruction BRAM.
rsta_n  in  1  asynchronous active-low reset.
mem_en  out  1  BRAM read enable (ena).
mem_addr  out  ADDR_W  BRAM read address (addra).
mem_dout  in  DATA_W  BRAM read data (douta), valid the cycle after mem_en=1.
redirect_valid  in  1  execute requests PC change this cycle.
redirect_pc  in  ADDR_W  new fetch address.
instr_valid  out  1  instr/instr_pc hold a valid instruction.
instr_ready  in  1  decode accepts the instruction this cycle.
instr  out  DATA_W  fetched instruction.
instr_pc  out  ADDR_W  address of instr.
halted  out  1  fetch stopped on HALT (tied 0 without IFU_HALT_EN).

Behaviour:
- Reset (async assert, sync release): state=WAIT, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, skid empty, in-flight=0, mem_en=0, halted=0.
- States: WAIT (1 cycle after reset release, no issue; lets BRAM reset settle) -> RUN. RUN -> HALT only with IFU_HALT_EN. HALT -> RUN only on redirect_valid.
- mem_en and mem_addr are combinational from registered state. mem_addr=pc always; mem_en=1 only when issuing.
- Issue rule in RUN: issue when occ < 2, where occ = (instr_valid & ~instr_ready) + skid_valid + in_flight. On issue: pc <= pc+1 (mod 2^ADDR_W, 31 wraps to 0), in_flight <= 1, the issued PC is tracked alongside.
- Return: the cycle after issue, mem_dout is loaded into the output register if it is empty or being consumed; otherwise it goes to the 1-entry skid buffer. Skid drains into the output register first, so order is preserved.
- Latency: issue in cycle N -> instr_valid in cycle N+2. Steady throughput is 1 instr/cycle while instr_ready=1.
- Stall: instr, instr_pc and instr_valid are held stable while instr_valid & ~instr_ready. No instruction is ever dropped or duplicated.
- Redirect (highest priority, beats ready and issue in the same cycle):
  - clear instr_valid and skid;
  - mark any in-flight return squashed, so it is discarded next cycle;
  - pc <= redirect_pc; no issue in the redirect cycle; issue resumes the next cycle.
- Redirect in WAIT is honoured: pc is loaded and state still moves to RUN.
- Reset mid-operation: all state returns to reset values immediately; any in-flight return is ignored.

Optional Feature:
Macro IFU_HALT_EN.
- Defined: an instruction with instr[31:26]==6'b111111 (HALT) is delivered normally. Fetch then enters HALT on its capture: no further issue, younger in-flight/skid data is discarded, halted=1. redirect_valid leaves HALT.
- Undefined: no HALT state, the opcode is not decoded, halted is tied 0.

Decomposition:
- Package kgp_risc_pkg: ADDR_W/DATA_W defaults, OPC_HALT constant, fetch state encodings (ST_WAIT, ST_RUN, ST_HALT).
- Sub-module ifu_skid_buf: 1-entry data+PC holding register with load/drain/flush. The FSM, issue logic and output register stay in instr_fetch_unit.

Test Plan:
1. BRAM word k = 32'hA000_0000+k. Release reset at 100 ns, instr_ready=1 -> mem_addr 0,1,2,3... from the 2nd cycle after release; instr_valid first asserts 2 cycles later with instr=A0000000, pc=0; one new instr per cycle.
2. instr_ready=0 for 5 cycles mid-stream at pc=4 -> instr=A0000004 held stable; mem_en low after the skid fills; on release, 4,5,6... delivered with no gap or duplicate.
3. redirect_valid with redirect_pc=20 while stalled with the skid full -> next delivered instr has pc=20, value A0000014; the squashed 5/6 never appear.
4. Free-run from pc=29 -> PC sequence 29,30,31,0,1 (wrap).
5. rsta_n low for 1 cycle mid-stream -> instr_valid=0 and mem_en=0 immediately; restarts at pc=0 after the WAIT cycle.
6. (IFU_HALT_EN) word 3 = 32'hFC00_0000 -> pcs 0..3 delivered, halted=1, no issue; redirect_pc=0 -> fetch restarts at 0.
